// File: rtl/sort_row_loader_pkg.sv
// Shared types and helpers for the sorter row loader.
// Default element count / width mirror the output buffer geometry.
package sort_row_loader_pkg;

  localparam int ARRAYWIDTH          = 8;
  localparam int OUTPUT_BUF_DATASIZE = 16;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    SORT   = 2'd2,
    OUT    = 2'd3
  } state_e;

  localparam logic [OUTPUT_BUF_DATASIZE-1:0] PAD_MIN =
    {1'b1, {(OUTPUT_BUF_DATASIZE-1){1'b0}}};

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sort_row_loader_row_pack_buf.sv
// N x DW slot register file: indexed write, pad-fill above
// the written slot, flat packed row output (slot k at k*DW).
module row_pack_buf
  import sort_row_loader_pkg::*;
#(
  parameter int  N  = ARRAYWIDTH,
  parameter int  DW = OUTPUT_BUF_DATASIZE,
  localparam int CW = clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic            pad_en,
  input  logic [CW-1:0]   wr_idx,
  input  logic [DW-1:0]   wr_data,
  output logic [N*DW-1:0] row
);

  localparam logic [DW-1:0] PAD = {1'b1, {(DW-1){1'b0}}};

  logic [DW-1:0] slot_q [N];
  logic [DW-1:0] slot_d [N];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      slot_d[k] = slot_q[k];
      if (wr_en && (CW'(k) == wr_idx)) begin
        slot_d[k] = wr_data;
      end else if (pad_en && (CW'(k) > wr_idx)) begin
        slot_d[k] = PAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  always_comb begin
    row = '0;
    for (int k = 0; k < N; k++) begin
      row[k*DW +: DW] = slot_q[k];
    end
  end

endmodule

// File: rtl/sort_row_loader.sv
// Packs a serial element stream into one sorter row, runs the sorter
// and hands the row max downstream. Option: SORT_LOADER_MAXCHECK_EN.
module sort_row_loader
  import sort_row_loader_pkg::*;
#(
  parameter int  N        = ARRAYWIDTH,
  parameter int  DW       = OUTPUT_BUF_DATASIZE,
  parameter int  SORT_LAT = N + 2,
  localparam int CW       = clog2(N + 1),
  localparam int TW       = clog2(SORT_LAT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_data,
  input  logic            s_last,
  output logic            sort_en,
  output logic [N*DW-1:0] sort_in,
  input  logic [DW-1:0]   sort_max,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   m_max,
  output logic [CW-1:0]   m_count,
`ifdef SORT_LOADER_MAXCHECK_EN
  output logic            max_err,
`endif
  output logic            busy
);

  state_e        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] m_max_q, m_max_d;
  logic          m_valid_q, m_valid_d;
  logic          s_ready_q, s_ready_d;
  logic          sort_en_q, sort_en_d;
  logic          busy_q, busy_d;

  logic wr_en;
  logic close;

  assign wr_en = (state_q == FILL) && s_valid && s_ready_q;
  assign close = wr_en && (s_last || (idx_q == CW'(N - 1)));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    cnt_d     = cnt_q;
    m_max_d   = m_max_q;
    m_valid_d = m_valid_q;
    s_ready_d = s_ready_q;
    sort_en_d = sort_en_q;
    busy_d    = busy_q;
    unique case (state_q)
      FILL: begin
        if (wr_en) begin
          idx_d = idx_q + CW'(1);
        end
        if (close) begin
          count_d   = idx_q + CW'(1);
          state_d   = LAUNCH;
          s_ready_d = 1'b0;
          sort_en_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      LAUNCH: begin
        cnt_d   = TW'(SORT_LAT - 1);
        state_d = SORT;
      end
      SORT: begin
        if (cnt_q == '0) begin
          m_max_d   = sort_max;
          m_valid_d = 1'b1;
          sort_en_d = 1'b0;
          state_d   = OUT;
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          idx_d     = '0;
          s_ready_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      idx_q     <= '0;
      count_q   <= '0;
      cnt_q     <= '0;
      m_max_q   <= '0;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b1;
      sort_en_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      cnt_q     <= cnt_d;
      m_max_q   <= m_max_d;
      m_valid_q <= m_valid_d;
      s_ready_q <= s_ready_d;
      sort_en_q <= sort_en_d;
      busy_q    <= busy_d;
    end
  end

`ifdef SORT_LOADER_MAXCHECK_EN
  // Padding is most-negative, so it never changes the row max.
  logic [DW-1:0] run_max_q, run_max_d;
  logic          max_err_q, max_err_d;

  always_comb begin
    run_max_d = run_max_q;
    max_err_d = max_err_q;
    if (wr_en) begin
      if ((idx_q == '0) ||
          ($signed(s_data) > $signed(run_max_q))) begin
        run_max_d = s_data;
      end
    end
    if ((state_q == SORT) && (cnt_q == '0)) begin
      max_err_d = (sort_max != run_max_q);
    end else if ((state_q == OUT) && m_ready) begin
      max_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_max_q <= '0;
      max_err_q <= 1'b0;
    end else begin
      run_max_q <= run_max_d;
      max_err_q <= max_err_d;
    end
  end

  assign max_err = max_err_q;
`endif

  row_pack_buf #(
    .N  (N),
    .DW (DW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .pad_en  (close),
    .wr_idx  (idx_q),
    .wr_data (s_data),
    .row     (sort_in)
  );

  assign s_ready = s_ready_q;
  assign sort_en = sort_en_q;
  assign m_valid = m_valid_q;
  assign m_max   = m_max_q;
  assign m_count = count_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_sort_row_loader.sv
// Directed bench for sort_row_loader (N=8, DW=16, SORT_LAT=10)
// with a behavioural max-finding sorter driving sort_max.
module tb_sort_row_loader;

  localparam int N  = 8;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          sort_en;
  logic [N*DW-1:0] sort_in;
  logic [DW-1:0] sort_max;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_max;
  logic [3:0]    m_count;
  logic          busy;
`ifdef SORT_LOADER_MAXCHECK_EN
  logic          max_err;
`endif

  logic          bad_en;
  logic [DW-1:0] bad_val;

  int checks;
  int failures;
  int lat;
  int en_cyc;
  int bad;

  sort_row_loader dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .sort_en  (sort_en),
    .sort_in  (sort_in),
    .sort_max (sort_max),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_max    (m_max),
    .m_count  (m_count),
`ifdef SORT_LOADER_MAXCHECK_EN
    .max_err  (max_err),
`endif
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    logic [DW-1:0] mx;
    mx = sort_in[DW-1:0];
    for (int k = 1; k < N; k++) begin
      if ($signed(sort_in[k*DW +: DW]) > $signed(mx)) begin
        mx = sort_in[k*DW +: DW];
      end
    end
    sort_max = bad_en ? bad_val : mx;
  end

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit last);
    bit rdy;
    bit done;
    int t;
    t = 0;
    done = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!done) begin
      rdy = s_ready;
      tick();
      t++;
      if (rdy) begin
        done = 1'b1;
      end else if (t > 200) begin
        check("send_timeout", 1, 0);
        done = 1'b1;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_row(input logic [DW-1:0] v [8],
                          input int n, input bit last);
    for (int i = 0; i < n; i++) begin
      send(v[i], last && (i == n - 1));
    end
  endtask

  task automatic wait_m(output int l, output int e);
    l = 0;
    e = 0;
    while (!m_valid && l < 200) begin
      e += int'(sort_en);
      tick();
      l++;
    end
    check("m_valid_seen", m_valid, 1);
    check("sort_en_off", sort_en, 0);
  endtask

  task automatic handshake();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("hs_m_valid", m_valid, 0);
    check("hs_s_ready", s_ready, 1);
    check("hs_busy", busy, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;
    s_last   = 1'b0;
    m_ready  = 1'b0;
    bad_en   = 1'b0;
    bad_val  = '0;
    repeat (2) tick();
    check("rst_s_ready", s_ready, 1);
    check("rst_sort_en", sort_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_max", m_max, 0);
    check("rst_m_count", m_count, 0);
    check("rst_busy", busy, 0);
    check("rst_sort_in", sort_in, 0);
`ifdef SORT_LOADER_MAXCHECK_EN
    check("rst_max_err", max_err, 0);
`endif
    rst = 1'b0;
    tick();

    // full row, s_last on the 8th element
    send_row('{16'h0003, 16'hFFFF, 16'h0007, 16'h0000,
               16'h0005, 16'h0002, 16'hFFF8, 16'h0004}, 8, 1'b1);
    check("r1_s_ready_low", s_ready, 0);
    check("r1_busy", busy, 1);
    wait_m(lat, en_cyc);
    check("r1_latency", lat, 11);
    check("r1_sort_en_cycles", en_cyc, 11);
    check("r1_sort_in", sort_in,
          128'h0004_FFF8_0002_0005_0000_0007_FFFF_0003);
    check("r1_m_max", m_max, 16'h0007);
    check("r1_m_count", m_count, 4'd8);
`ifdef SORT_LOADER_MAXCHECK_EN
    check("r1_max_err", max_err, 0);
`endif
    handshake();

    // short row padded with most-negative
    send_row('{16'h0005, 16'hFFFD, 16'h0002, 16'h0000,
               16'h0000, 16'h0000, 16'h0000, 16'h0000}, 3, 1'b1);
    wait_m(lat, en_cyc);
    check("r2_latency", lat, 11);
    check("r2_sort_in", sort_in,
          128'h8000_8000_8000_8000_8000_0002_FFFD_0005);
    check("r2_m_max", m_max, 16'h0005);
    check("r2_m_count", m_count, 4'd3);
    handshake();

    // nine offered, no s_last: implicit close at 8
    send_row('{16'h000A, 16'h0014, 16'h001E, 16'h0028,
               16'h0032, 16'h003C, 16'h0046, 16'h0050}, 8, 1'b0);
    s_valid = 1'b1;
    s_data  = 16'h005A;
    s_last  = 1'b1;
    check("r3_ninth_stalled", s_ready, 0);
    wait_m(lat, en_cyc);
    check("r3_m_max", m_max, 16'h0050);
    check("r3_m_count", m_count, 4'd8);
    handshake();
    send(16'h005A, 1'b1);
    wait_m(lat, en_cyc);
    check("r3b_m_max", m_max, 16'h005A);
    check("r3b_m_count", m_count, 4'd1);
    check("r3b_sort_in", sort_in,
          128'h8000_8000_8000_8000_8000_8000_8000_005A);
    handshake();

    // all negative: padding must never win
    send_row('{16'hFFF7, 16'hFFFE, 16'hFFFB, 16'hFFF9,
               16'hFFFD, 16'hFFFC, 16'hFFFA, 16'hFFF8}, 8, 1'b1);
    wait_m(lat, en_cyc);
    check("r4_m_max", m_max, 16'hFFFE);
    check("r4_m_count", m_count, 4'd8);
    handshake();

    // back-pressure for 20 cycles with input offered
    send_row('{16'h0001, 16'h0002, 16'h0000, 16'h0000,
               16'h0000, 16'h0000, 16'h0000, 16'h0000}, 2, 1'b1);
    wait_m(lat, en_cyc);
    s_valid = 1'b1;
    s_data  = 16'h0033;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!(m_valid && m_max == 16'h0002 && m_count == 4'd2 &&
            !s_ready && busy)) begin
        bad++;
      end
    end
    check("bp_unstable_cycles", bad, 0);
    s_valid = 1'b0;
    handshake();
    check("bp_m_count_held", m_count, 4'd2);

    // reset in the middle of SORT
    send_row('{16'h0064, 16'h0065, 16'h0066, 16'h0067,
               16'h0068, 16'h0069, 16'h006A, 16'h006B}, 8, 1'b1);
    repeat (4) tick();
    check("r6_in_sort", sort_en, 1);
    rst = 1'b1;
    tick();
    check("r6_rst_sort_en", sort_en, 0);
    check("r6_rst_s_ready", s_ready, 1);
    check("r6_rst_m_valid", m_valid, 0);
    check("r6_rst_busy", busy, 0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_valid) bad++;
    end
    check("r6_no_stale_m_valid", bad, 0);
    send_row('{16'hFFFF, 16'h0006, 16'h0000, 16'h0000,
               16'h0000, 16'h0000, 16'h0000, 16'h0000}, 2, 1'b1);
    wait_m(lat, en_cyc);
    check("r6_m_max", m_max, 16'h0006);
    check("r6_m_count", m_count, 4'd2);
    handshake();

`ifdef SORT_LOADER_MAXCHECK_EN
    bad_en  = 1'b1;
    bad_val = 16'h1234;
    send_row('{16'h0001, 16'h0002, 16'h0003, 16'h0000,
               16'h0000, 16'h0000, 16'h0000, 16'h0000}, 3, 1'b1);
    wait_m(lat, en_cyc);
    check("mc_m_max", m_max, 16'h1234);
    check("mc_max_err", max_err, 1);
    tick();
    check("mc_max_err_held", max_err, 1);
    handshake();
    check("mc_max_err_clr", max_err, 0);
    bad_en = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sort_row_loader.md
Name: sort_row_loader

Overview:
- Producer side of the systolic odd-even sorter's input interface.
- Accepts a serial stream of output-buffer words with valid/ready and packs them into one ARRAYWIDTH-wide row.
- Drives the sorter's `in`/`en`, waits the fixed sort latency, then captures the sorter's `max_out`.
- Presents the row max downstream (softmax max-subtract stage) on a valid/ready handshake.

Parameters:
- N, default `ARRAYWIDTH (8): elements per row; must be even and ≥2.
- DW, default `OUTPUT_BUF_DATASIZE (16): element width, signed two's complement.
- SORT_LAT, default N+2: cycles from `sort_en` high to `sort_max` valid.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous reset, active-high.
- s_valid, input, 1: input element valid.
- s_ready, output, 1: loader can accept an element.
- s_data, input, DW: input element.
- s_last, input, 1: final element of the row.
- sort_en, output, 1: enable to sorter `en`.
- sort_in, output, N*DW: packed row; element k at bits [(k+1)*DW-1 : k*DW].
- sort_max, input, DW: sorter `max_out`.
- m_valid, output, 1: row max valid.
- m_ready, input, 1: downstream accepts the max.
- m_max, output, DW: captured row max.
- m_count, output, clog2(N+1): number of real elements in the row.
- busy, output, 1: high in any state other than FILL.

Behaviour:
- Reset, on a synchronous rst high: state FILL, index 0, sort_in all bits 0, sort_en 0, s_ready 1, m_valid 0, m_max 0, m_count 0, busy 0.
- Reset mid-operation: aborts any row in any state; no m_valid is produced for the aborted row.
- State machine, FILL → LAUNCH → SORT → OUT → FILL.
- FILL:
  - s_ready=1. On s_valid&s_ready, write s_data to slot idx, then idx++.
  - Row closes on the accept with s_last=1, or on the accept of the Nth element (implicit last).
  - On close: latch m_count = elements accepted; fill slots idx+1..N-1 with the most-negative value (1 followed by DW-1 zeros); go to LAUNCH.
  - s_last on the first element gives a count-1 row, padded.
- LAUNCH:
  - s_ready=0, sort_en=1 for exactly one cycle (sorter write phase).
  - sort_in is stable from this cycle until OUT is entered.
  - Load wait counter = SORT_LAT-1; go to SORT.
- SORT:
  - sort_en stays 1 (the sorter holds its compare phases on en); counter decrements each cycle.
  - At counter 0: capture sort_max into m_max, set m_valid=1, deassert sort_en; go to OUT.
  - Total latency from the closing accept to m_valid = SORT_LAT+1 cycles.
- OUT:
  - m_valid=1 with m_max/m_count held stable until m_ready. Back-pressure is unbounded.
  - On m_valid&m_ready: m_valid=0, idx=0, go to FILL; s_ready becomes 1 the next cycle.
  - sort_in is not cleared on exit; stale slots are overwritten by the next row.
- Input blocking: s_ready=0 in LAUNCH/SORT/OUT. The loader never accepts elements of the next row early.
- Widths: no arithmetic on data; idx and counter wrap is never reached by construction.

Optional Feature:
- Macro: SORT_LOADER_MAXCHECK_EN.
- Defined:
  - A signed running max register updates on every FILL accept; the first element initialises it.
  - On the SORT→OUT capture, compare sort_max with the running max.
  - Extra output port max_err (1 bit): set on mismatch, held until the OUT handshake, reset 0.
- Undefined: no running-max register and no max_err port; behaviour otherwise identical.

Decomposition:
- Shared package / config include:
  - state encoding localparams (FILL, LAUNCH, SORT, OUT);
  - the DW-bit most-negative pad constant;
  - the clog2 helper.
- One natural sub-module: row_pack_buf, an N×DW slot register file with indexed write, pad-fill and flat packed output. The FSM stays in the top level.

Test Plan:
- Full row 3,-1,7,0,5,2,-8,4 at N=8 with s_last on the 8th element → sort_en high 1+SORT_LAT cycles; m_max=7, m_count=8, m_valid at closing accept + SORT_LAT+1.
- Short row 5,-3,2 with s_last on the 3rd element → slots 3..7 = 0x8000; m_max=5, m_count=3.
- Nine elements offered with no s_last → 8 accepted and row closes; the 9th is stalled (s_ready=0) and is accepted as element 0 of the next row after the m handshake.
- All-negative row -9,-2,-5,-7,-3,-4,-6,-8 → m_max=-2; padding never wins.
- m_ready held low for 20 cycles in OUT → m_valid, m_max and m_count stable; no s_ready; clean return to FILL after the handshake.
- rst asserted mid-SORT → next cycle sort_en=0, s_ready=1, m_valid=0; a following row produces a correct max. With SORT_LOADER_MAXCHECK_EN and sort_max forced to a wrong value → max_err=1.
